// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select encodings and the in-flight destination record
package hazard_pkg;
  localparam logic [2:0] FWD_RF   = 3'd0;
  localparam logic [2:0] FWD_MEM1 = 3'd1;
  localparam logic [2:0] FWD_MEM2 = 3'd2;
  localparam logic [2:0] FWD_WB   = 3'd3;
  localparam logic [2:0] FWD_WBFW = 3'd4;
  localparam int INFLIGHT_DEPTH = 5;
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       is_load;
  } inflight_t;
  function automatic logic live(input inflight_t e);
    return e.valid & e.regwrite & (e.dst != 5'd0);
  endfunction
endpackage

// File: rtl/fwd_pick.sv
// fwd_pick: priority match of one ID source against age1..age4, youngest producer wins
module fwd_pick
  import hazard_pkg::*;
(
  input  logic [4:0]      src_i,
  input  logic            use_i,
  input  inflight_t [3:0] age_i,
  output logic [2:0]      sel_o,
  output logic            load_hit_o
);
  logic [3:0] hit;
  logic       unused_ld;
  for (genvar i = 0; i < 4; i++) begin : g_hit
    assign hit[i] = use_i & live(age_i[i]) & (age_i[i].dst == src_i);
  end
  assign sel_o = hit[0] ? FWD_MEM1 : hit[1] ? FWD_MEM2 : hit[2] ? FWD_WB : hit[3] ? FWD_WBFW : FWD_RF;
  // only loads still in EX/MEM1 are too late to forward from
  assign load_hit_o = (hit[0] & age_i[0].is_load) | (hit[1] & age_i[1].is_load);
  assign unused_ld = age_i[2].is_load ^ age_i[3].is_load;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall detection and registered EX forwarding selects
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int NSRC = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs,
  input  logic [4:0]              id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic [4:0]              id_dst,
  input  logic                    id_regwrite,
  input  logic                    id_is_load,
  input  logic                    flush,
  input  logic                    freeze,
  output logic                    stall_id,
  output logic [$clog2(NSRC)-1:0] ex_fwd_a,
  output logic [$clog2(NSRC)-1:0] ex_fwd_b,
  output logic                    ex_bubble,
  output logic [31:0]             stall_count
);
  inflight_t [INFLIGHT_DEPTH-1:0] age_q, age_d;
  inflight_t  rec;
  logic [2:0] sel_a, sel_b, fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       hit_a, hit_b, accept, bubble_q, bubble_d, unused_wbfw;
  logic [31:0] cnt_q, cnt_d;
  fwd_pick u_pick_a (.src_i(id_rs), .use_i(id_use_rs), .age_i(age_q[3:0]), .sel_o(sel_a), .load_hit_o(hit_a));
  fwd_pick u_pick_b (.src_i(id_rt), .use_i(id_use_rt), .age_i(age_q[3:0]), .sel_o(sel_b), .load_hit_o(hit_b));
  assign stall_id = id_valid & ~flush & (hit_a | hit_b);
  assign accept   = id_valid & ~flush & ~stall_id;
  always_comb begin
    rec      = accept ? '{valid: 1'b1, dst: id_dst, regwrite: id_regwrite, is_load: id_is_load} : '0;
    age_d    = {age_q[INFLIGHT_DEPTH-2:0], rec};
    fwd_a_d  = accept ? sel_a : FWD_RF;
    fwd_b_d  = accept ? sel_b : FWD_RF;
    bubble_d = ~accept;
    cnt_d    = (stall_id && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      age_q    <= '0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
    end else if (!freeze) begin
      age_q    <= age_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end
  // WBFW entry is tracked for pipeline bookkeeping but is past every forwarding window
  assign unused_wbfw = ^age_q[INFLIGHT_DEPTH-1];
  assign ex_fwd_a    = fwd_a_q;
  assign ex_fwd_b    = fwd_b_q;
  assign ex_bubble   = bubble_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed vectors with a queue scoreboard checked on the falling edge
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_regwrite = 0, id_is_load = 0, flush = 0, freeze = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
  logic stall_id, ex_bubble;
  logic [2:0] ex_fwd_a, ex_fwd_b;
  logic [31:0] stall_count;
  int checks = 0, errors = 0, nstep = 0;
  typedef struct {
    int          id;
    logic        s;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        bub;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  hazard_fwd_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .flush(flush), .freeze(freeze), .stall_id(stall_id),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_bubble(ex_bubble), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0d want %0d", n, id, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall_id", e.id, {31'd0, stall_id}, {31'd0, e.s});
      chk("ex_fwd_a", e.id, {29'd0, ex_fwd_a}, {29'd0, e.a});
      chk("ex_fwd_b", e.id, {29'd0, ex_fwd_b}, {29'd0, e.b});
      chk("ex_bubble", e.id, {31'd0, ex_bubble}, {31'd0, e.bub});
      chk("stall_count", e.id, stall_count, e.cnt);
    end
  end
  // drive one cycle of ID inputs; expectations are the outputs visible during that cycle
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic [4:0] dst, input logic rw, input logic ld,
                      input logic fl, input logic fz, input logic rst, input logic es,
                      input logic [2:0] ea, input logic [2:0] eb, input logic ebub, input logic [31:0] ecnt);
    @(posedge clk); #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_regwrite = rw; id_is_load = ld; flush = fl; freeze = fz; reset = rst;
    q.push_back('{nstep, es, ea, eb, ebub, ecnt});
    nstep++;
  endtask
  task automatic nop(input logic [2:0] ea, input logic [2:0] eb, input logic ebub, input logic [31:0] ecnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, ebub, ecnt);
  endtask
  task automatic drain(input int n, input logic [31:0] ecnt);
    for (int i = 0; i < n; i++) nop(0, 0, 1, ecnt);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    // ALU chain: forward from MEM1
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 3, 4, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1, 0, 0, 0);
    drain(4, 0);
    // load-use: two stalls, then WB forward on rt
    step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 6, 5, 1, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 6, 5, 1, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    step(1, 6, 5, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    nop(0, 3, 0, 2);
    drain(4, 2);
    // r0 load and non-writing store never match
    step(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step(1, 1, 2, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step(1, 4, 4, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    nop(0, 0, 0, 2);
    drain(4, 2);
    // priority: r7 at age3 and age1, youngest wins
    step(1, 1, 2, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 1, 2, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step(1, 1, 2, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step(1, 7, 7, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    nop(1, 1, 0, 2);
    drain(4, 2);
    // WBFW-only producer; rt matches but is not used
    step(1, 1, 2, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    nop(0, 0, 0, 2);
    nop(0, 0, 1, 2);
    nop(0, 0, 1, 2);
    step(1, 14, 14, 1, 0, 15, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    nop(4, 0, 0, 2);
    drain(4, 2);
    // freeze for 3 cycles inside a load-use stall
    step(1, 1, 2, 1, 0, 16, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 16, 2, 1, 1, 17, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) step(1, 16, 2, 1, 1, 17, 1, 0, 0, 1, 0, 1, 0, 0, 1, 3);
    step(1, 16, 2, 1, 1, 17, 1, 0, 0, 0, 0, 1, 0, 0, 1, 3);
    step(1, 16, 2, 1, 1, 17, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    nop(3, 0, 0, 4);
    drain(4, 4);
    // flush on a hazard cycle
    step(1, 1, 2, 1, 0, 18, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4);
    step(1, 18, 2, 1, 1, 19, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4);
    nop(0, 0, 1, 4);
    drain(4, 4);
    // reset during the second stall cycle
    step(1, 1, 2, 1, 0, 20, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4);
    step(1, 20, 2, 1, 1, 21, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4);
    step(1, 20, 2, 1, 1, 21, 1, 0, 0, 0, 1, 1, 0, 0, 1, 5);
    step(1, 20, 2, 1, 1, 21, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
